// File: rtl/intercore_mailbox_if.sv
// AXI-lite write port (sender core) and read port (receiver core) of the mailbox.
`timescale 1ns/1ps
interface intercore_mailbox_if;
  logic        s_awvalid;
  logic        s_awready;
  logic [31:0] s_awaddr;
  logic        s_wvalid;
  logic        s_wready;
  logic [31:0] s_wdata;
  logic        s_bvalid;
  logic        s_bready;
  logic [1:0]  s_bresp;
  logic        r_arvalid;
  logic        r_arready;
  logic [31:0] r_araddr;
  logic        r_rvalid;
  logic        r_rready;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;

  modport master (
    output s_awvalid, s_awaddr, s_wvalid, s_wdata, s_bready,
    output r_arvalid, r_araddr, r_rready,
    input  s_awready, s_wready, s_bvalid, s_bresp,
    input  r_arready, r_rvalid, r_rdata, r_rresp
  );

  modport slave (
    input  s_awvalid, s_awaddr, s_wvalid, s_wdata, s_bready,
    input  r_arvalid, r_araddr, r_rready,
    output s_awready, s_wready, s_bvalid, s_bresp,
    output r_arready, r_rvalid, r_rdata, r_rresp
  );
endinterface

// File: rtl/intercore_mailbox.sv
// Inter-core mailbox: AXI-lite writes push a FIFO, reads pop it; write response 2 cycles
// after AW/W handshake, read data 1 cycle after AR; one outstanding transaction per side.
`timescale 1ns/1ps
module intercore_mailbox #(
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  intercore_mailbox_if.slave   bus,
  output logic                 msg_pending,
  output logic                 overflow
);
  localparam int PW = $clog2(DEPTH);

  logic          aw_held, w_held, bvalid, awready, wready;
  logic [1:0]    aw_sel, bresp;
  logic [31:0]   wdata_q;
  logic          rvalid, arready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;

  logic          aw_hs, w_hs, ar_hs, commit, full, empty, push_ok, pop_ok;
  logic [1:0]    ar_sel;
  logic          aw_held_n, w_held_n, bvalid_n, rvalid_n, overflow_n;
  logic [CW-1:0] count_n;
  logic [31:0]   status;

  wire unused_addr = &{1'b0, bus.s_awaddr[31:4], bus.s_awaddr[1:0],
                       bus.r_araddr[31:4], bus.r_araddr[1:0]};

  assign aw_hs   = bus.s_awvalid && awready;
  assign w_hs    = bus.s_wvalid && wready;
  assign ar_hs   = bus.r_arvalid && arready;
  assign ar_sel  = bus.r_araddr[3:2];
  assign commit  = aw_held && w_held;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // Both decisions use the pre-edge count, so same-cycle push/pop never see each other.
  assign push_ok = commit && (aw_sel == 2'd0) && !full;
  assign pop_ok  = ar_hs && (ar_sel == 2'd0) && !empty;
  assign status  = {16'b0, 8'(count), 6'b0, full, empty};

  always_comb begin
    aw_held_n  = commit ? 1'b0 : (aw_held || aw_hs);
    w_held_n   = commit ? 1'b0 : (w_held || w_hs);
    bvalid_n   = commit ? 1'b1 : (bvalid && !bus.s_bready);
    rvalid_n   = ar_hs  ? 1'b1 : (rvalid && !bus.r_rready);
    count_n    = count;
    if (push_ok && !pop_ok)
      count_n = count + CW'(1);
    else if (pop_ok && !push_ok)
      count_n = count - CW'(1);
    overflow_n = overflow;
    if (commit && aw_sel == 2'd1 && wdata_q[0])
      overflow_n = 1'b0;
    if (commit && aw_sel == 2'd0 && full)
      overflow_n = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wptr] <= wdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_held     <= 1'b0;
      w_held      <= 1'b0;
      bvalid      <= 1'b0;
      awready     <= 1'b0;
      wready      <= 1'b0;
      aw_sel      <= 2'd0;
      wdata_q     <= '0;
      bresp       <= 2'b00;
      rvalid      <= 1'b0;
      arready     <= 1'b0;
      rdata       <= '0;
      rresp       <= 2'b00;
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      msg_pending <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      aw_held     <= aw_held_n;
      w_held      <= w_held_n;
      bvalid      <= bvalid_n;
      awready     <= !aw_held_n && !bvalid_n;
      wready      <= !w_held_n && !bvalid_n;
      rvalid      <= rvalid_n;
      arready     <= !rvalid_n;
      count       <= count_n;
      msg_pending <= (count_n != '0);
      overflow    <= overflow_n;
      if (aw_hs) aw_sel  <= bus.s_awaddr[3:2];
      if (w_hs)  wdata_q <= bus.s_wdata;
      if (push_ok) wptr <= wptr + PW'(1);
      if (pop_ok)  rptr <= rptr + PW'(1);
      if (commit)
        bresp <= (push_ok || aw_sel == 2'd1) ? 2'b00 : 2'b10;
      if (ar_hs) begin
        unique case (ar_sel)
          2'd0: begin
            rdata <= empty ? 32'h0 : mem[rptr];
            rresp <= empty ? 2'b10 : 2'b00;
          end
          2'd1: begin
            rdata <= status;
            rresp <= 2'b00;
          end
          default: begin
            rdata <= 32'h0;
            rresp <= 2'b10;
          end
        endcase
      end
    end
  end

  assign bus.s_awready = awready;
  assign bus.s_wready  = wready;
  assign bus.s_bvalid  = bvalid;
  assign bus.s_bresp   = bresp;
  assign bus.r_arready = arready;
  assign bus.r_rvalid  = rvalid;
  assign bus.r_rdata   = rdata;
  assign bus.r_rresp   = rresp;
endmodule

// File: tb/tb_intercore_mailbox.sv
// Directed bench for intercore_mailbox: vector table plus hand-timed corner sequences.
`timescale 1ns/1ps
module tb_intercore_mailbox;
  logic clk = 1'b0;
  logic rst;
  logic msg_pending, overflow;
  int   checks = 0;
  int   failures = 0;

  intercore_mailbox_if bus ();

  intercore_mailbox #(.DEPTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .msg_pending (msg_pending),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  resp;
    logic [31:0] rdata;
    bit          pend;
    bit          ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit rd, input logic [31:0] addr, data, input logic [1:0] resp,
                     input logic [31:0] rdata, input bit pend, ovf);
    vec_t v;
    v.rd = rd; v.addr = addr; v.data = data; v.resp = resp;
    v.rdata = rdata; v.pend = pend; v.ovf = ovf;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, d, output logic [1:0] resp, output int lat);
    bit aw_d, w_d, aw_h, w_h;
    int n;
    aw_d = 0; w_d = 0; n = 0;
    bus.s_awaddr = a; bus.s_wdata = d;
    bus.s_awvalid = 1; bus.s_wvalid = 1; bus.s_bready = 1;
    while (!(aw_d && w_d) && n < 20) begin
      aw_h = bus.s_awvalid && bus.s_awready;
      w_h  = bus.s_wvalid && bus.s_wready;
      tick(); n++;
      if (aw_h) begin aw_d = 1; bus.s_awvalid = 0; end
      if (w_h)  begin w_d = 1;  bus.s_wvalid = 0;  end
    end
    lat = 0;
    while (!bus.s_bvalid && n < 20) begin tick(); n++; lat++; end
    resp = bus.s_bresp;
    if (!bus.s_bvalid) begin
      checks++; failures++;
      $display("FAIL write_timeout: addr %h got no bvalid, expected bvalid within 20 cycles", a);
    end
    tick();
    bus.s_bready = 0; bus.s_awvalid = 0; bus.s_wvalid = 0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] data,
                         output logic [1:0] resp, output int lat);
    bit done, h;
    int n;
    done = 0; n = 0;
    bus.r_araddr = a; bus.r_arvalid = 1; bus.r_rready = 1;
    while (!done && n < 20) begin
      h = bus.r_arvalid && bus.r_arready;
      tick(); n++;
      if (h) begin done = 1; bus.r_arvalid = 0; end
    end
    lat = 0;
    while (!bus.r_rvalid && n < 20) begin tick(); n++; lat++; end
    data = bus.r_rdata; resp = bus.r_rresp;
    if (!bus.r_rvalid) begin
      checks++; failures++;
      $display("FAIL read_timeout: addr %h got no rvalid, expected rvalid within 20 cycles", a);
    end
    tick();
    bus.r_rready = 0; bus.r_arvalid = 0;
  endtask

  // AW+W at one edge, AR timed to land on the commit edge.
  task automatic push_pop(input logic [31:0] wd, output logic [31:0] rd, output logic [1:0] rr,
                          output logic [3:0] side);
    bus.s_awaddr = 32'h0; bus.s_wdata = wd;
    bus.s_awvalid = 1; bus.s_wvalid = 1; bus.s_bready = 1; bus.r_rready = 1;
    tick();
    bus.s_awvalid = 0; bus.s_wvalid = 0;
    bus.r_araddr = 32'h0; bus.r_arvalid = 1;
    tick();
    bus.r_arvalid = 0;
    rd = bus.r_rdata; rr = bus.r_rresp;
    side = {bus.s_bvalid, bus.r_rvalid, bus.s_bresp == 2'b00, msg_pending};
    tick();
    bus.s_bready = 0; bus.r_rready = 0;
  endtask

  logic [31:0] rdv;
  logic [1:0]  rsp;
  logic [3:0]  side;
  int          lat;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected finish before 200us");
    $fatal(1);
  end

  initial begin
    rst = 1;
    bus.s_awvalid = 0; bus.s_awaddr = 0; bus.s_wvalid = 0; bus.s_wdata = 0; bus.s_bready = 0;
    bus.r_arvalid = 0; bus.r_araddr = 0; bus.r_rready = 0;

    add(0, 32'h0, 32'hA5A5_0001, 2'b00, 32'h0, 1, 0);
    add(1, 32'h4, 32'h0, 2'b00, 32'h0000_0100, 1, 0);
    add(1, 32'h0, 32'h0, 2'b00, 32'hA5A5_0001, 0, 0);
    for (int i = 0; i < 8; i++) add(0, 32'h0, 32'h10 + i, 2'b00, 32'h0, 1, 0);
    add(0, 32'h0, 32'h99, 2'b10, 32'h0, 1, 1);
    add(1, 32'h4, 32'h0, 2'b00, 32'h0000_0802, 1, 1);
    add(0, 32'h4, 32'h0, 2'b00, 32'h0, 1, 1);
    for (int i = 0; i < 8; i++) add(1, 32'h0, 32'h0, 2'b00, 32'h10 + i, i < 7, 1);
    add(1, 32'h0, 32'h0, 2'b10, 32'h0, 0, 1);
    add(0, 32'h4, 32'h1, 2'b00, 32'h0, 0, 0);
    add(0, 32'h8, 32'hDEAD_BEEF, 2'b10, 32'h0, 0, 0);
    add(1, 32'h4, 32'h0, 2'b00, 32'h0000_0001, 0, 0);
    add(1, 32'h8, 32'h0, 2'b10, 32'h0, 0, 0);
    add(0, 32'hC, 32'h1234, 2'b10, 32'h0, 0, 0);
    add(1, 32'hC, 32'h0, 2'b10, 32'h0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", {bus.s_awready, bus.s_wready, bus.r_arready}, 3'b000);
    check("reset_valid", {bus.s_bvalid, bus.r_rvalid, msg_pending, overflow}, 4'b0000);
    check("reset_resp", {bus.s_bresp, bus.r_rresp}, 4'b0000);
    check("reset_rdata", bus.r_rdata, 32'h0);
    rst = 0;
    tick();
    check("post_reset_ready", {bus.s_awready, bus.s_wready, bus.r_arready}, 3'b111);

    foreach (vecs[i]) begin
      if (vecs[i].rd) begin
        do_read(vecs[i].addr, rdv, rsp, lat);
        check($sformatf("v%0d_rdata", i), rdv, vecs[i].rdata);
        check($sformatf("v%0d_rlat", i), lat, 0);
      end else begin
        do_write(vecs[i].addr, vecs[i].data, rsp, lat);
        check($sformatf("v%0d_blat", i), lat, 1);
      end
      check($sformatf("v%0d_resp", i), rsp, vecs[i].resp);
      check($sformatf("v%0d_pending", i), msg_pending, vecs[i].pend);
      check($sformatf("v%0d_overflow", i), overflow, vecs[i].ovf);
    end

    // W three cycles ahead of AW, bready low four cycles.
    bus.s_bready = 0; bus.s_wdata = 32'h55AA; bus.s_awaddr = 32'h0;
    check("split_wready_pre", bus.s_wready, 1'b1);
    bus.s_wvalid = 1;
    tick();
    bus.s_wvalid = 0;
    check("split_wready_held", bus.s_wready, 1'b0);
    tick(); tick();
    bus.s_awvalid = 1;
    tick();
    bus.s_awvalid = 0;
    check("split_no_b_yet", {bus.s_bvalid, bus.s_awready}, 2'b00);
    tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("split_hold%0d", i),
            {bus.s_bvalid, bus.s_bresp, bus.s_awready, bus.s_wready}, 5'b10000);
      tick();
    end
    bus.s_bready = 1;
    tick();
    bus.s_bready = 0;
    check("split_release", {bus.s_bvalid, bus.s_awready, bus.s_wready}, 3'b011);
    do_read(32'h4, rdv, rsp, lat);
    check("split_status", rdv, 32'h0000_0100);
    do_read(32'h0, rdv, rsp, lat);
    check("split_data", rdv, 32'h55AA);

    // Steady count=1 with concurrent push and pop, wrapping the pointers three times.
    do_write(32'h0, 32'd1000, rsp, lat);
    for (int k = 1; k <= 26; k++) begin
      push_pop(32'd1000 + k, rdv, rsp, side);
      check($sformatf("pp%0d_rdata", k), rdv, 32'd999 + k);
      check($sformatf("pp%0d_side", k), {side, rsp}, 6'b111100);
    end
    do_read(32'h4, rdv, rsp, lat);
    check("pp_status", rdv, 32'h0000_0100);
    do_read(32'h0, rdv, rsp, lat);
    check("pp_last", rdv, 32'd1026);

    // Pop on empty in the push's commit cycle: error, pushed word survives.
    push_pop(32'h77, rdv, rsp, side);
    check("empty_pp_resp", {rdv, rsp}, {32'h0, 2'b10});
    do_read(32'h0, rdv, rsp, lat);
    check("empty_pp_word", {rdv, rsp}, {32'h77, 2'b00});

    // Reset during an outstanding read with 5 words queued and overflow set.
    for (int i = 0; i < 9; i++) do_write(32'h0, 32'h200 + i, rsp, lat);
    check("rst_pre_ovf", {overflow, rsp}, 3'b110);
    do_read(32'h0, rdv, rsp, lat);
    do_read(32'h0, rdv, rsp, lat);
    bus.r_araddr = 32'h0; bus.r_arvalid = 1; bus.r_rready = 0;
    tick();
    bus.r_arvalid = 0;
    check("rst_pre_rvalid", bus.r_rvalid, 1'b1);
    rst = 1;
    tick();
    check("rst_mid_valid", {bus.r_rvalid, bus.s_bvalid, msg_pending, overflow}, 4'b0000);
    check("rst_mid_ready", {bus.s_awready, bus.s_wready, bus.r_arready}, 3'b000);
    rst = 0;
    tick();
    do_read(32'h4, rdv, rsp, lat);
    check("rst_status", rdv, 32'h0000_0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/intercore_mailbox.md
Name: intercore_mailbox

Overview:
- Downstream consumer of the per-core AXI-lite write stream that carries captured mailbox-address stores to the core-management interconnect.
- Buffers the sender core's writes in a FIFO and serves them to the receiver core through an AXI-lite read port (pop on read), plus a status register.
- Drives a level message-pending interrupt toward the receiving core.

Parameters:
- DEPTH, 8, FIFO entries; power of 2, at least 2.
- CW, $clog2(DEPTH+1), count width (derived; not overridden).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- s_awvalid  in  1  write address valid (sender core)
- s_awready  out  1  write address ready
- s_awaddr  in  32  write address; only [3:2] decoded
- s_wvalid  in  1  write data valid
- s_wready  out  1  write data ready
- s_wdata  in  32  write data
- s_bvalid  out  1  write response valid
- s_bready  in  1  write response ready
- s_bresp  out  2  00 OKAY, 10 SLVERR
- r_arvalid  in  1  read address valid (receiver core)
- r_arready  out  1  read address ready
- r_araddr  in  32  read address; only [3:2] decoded
- r_rvalid  out  1  read data valid
- r_rready  in  1  read data ready
- r_rdata  out  32  read data
- r_rresp  out  2  00 OKAY, 10 SLVERR
- msg_pending  out  1  FIFO non-empty, registered
- overflow  out  1  sticky: a push was rejected because the FIFO was full

Behaviour:
- Reset: all valid/ready registers, bvalid, rvalid, msg_pending and overflow go to 0; count, read pointer and write pointer go to 0; rdata = 0; bresp = rresp = 00. Reset mid-transaction drops in-flight handshakes and FIFO contents.
- Address map, [3:2]:
  - 0 = DATA. Write pushes; read pops.
  - 1 = STATUS. Read returns {16'b0, count zero-extended to 8 bits, 6'b0, full, empty}. Write with wdata[0]=1 clears overflow.
  - 2, 3 = invalid. Writes are dropped with SLVERR; reads return 0 with SLVERR.
- Write channel:
  - AW and W are accepted independently. s_awready = !aw_held && !s_bvalid; s_wready = !w_held && !s_bvalid.
  - An address or data beat is held after its handshake until the commit.
  - Commit happens in the cycle where aw_held and w_held are both set (both handshakes may complete in the same cycle, commit the cycle after).
  - At commit: perform the push or clear, assert s_bvalid next edge, release both held flags.
  - s_bvalid holds until s_bready; there is only one outstanding write.
- Push rules:
  - If DATA and not full: mem[wptr] = wdata, wptr wraps modulo DEPTH, OKAY.
  - If DATA and full: data is dropped, overflow is set to 1, SLVERR.
  - Full is evaluated before any same-cycle pop, so a push while full is rejected even if a pop occurs in the same cycle.
- Read channel:
  - r_arready = !r_rvalid.
  - On AR handshake, r_rvalid and rdata/rresp are registered at the next edge (1-cycle latency).
  - r_rvalid holds until r_rready; only one outstanding read.
  - DATA read, not empty: rdata = mem[rptr], rptr wraps, count decrements, OKAY.
  - DATA read, empty: rdata = 0, SLVERR, no pointer change.
  - Empty is evaluated before any same-cycle push, so a pop on an empty FIFO in the same cycle as a push returns SLVERR and the pushed word stays.
- Count:
  - Same-cycle successful push and pop leaves count unchanged and moves both pointers.
  - Count never exceeds DEPTH and never underflows.
- Status flags:
  - full = (count == DEPTH); empty = (count == 0).
  - msg_pending is registered from the next-state count != 0, so it is valid in the same cycle count updates.
- Overflow set and clear in the same cycle: set wins.

Test Plan:
- Reset, then write DATA 0xA5A5_0001 (AW and W same cycle) -> bvalid 2 cycles after handshake with OKAY; msg_pending=1; STATUS read returns 0x0000_0100.
- Push 8 words 0x10..0x17, then a 9th push 0x99 -> 9th gets SLVERR, overflow=1; STATUS = 0x0000_0802; 8 DATA reads return 0x10..0x17 in order, then a read returns 0 with SLVERR and msg_pending=0.
- W handshake 3 cycles before AW, with bready held low 4 cycles -> single push; bvalid held stable; awready and wready stay 0 until bready.
- With count=1, commit a push in the same cycle as a DATA pop handshake -> pop returns the old word, count stays 1, pointers wrap correctly across 3 full FIFO cycles (24+ words).
- Write STATUS with wdata=1 after an overflow -> overflow=0; access to address 0x8 -> write SLVERR with FIFO unchanged; read returns 0 with SLVERR.
- Assert rst while rvalid=1 and count=5 -> next cycle rvalid=0, count=0, msg_pending=0, all ready outputs 0.
